// File: rtl/pong_vga_renderer.sv
// Pong display stage: VGA timing generator plus a per-pixel renderer for two
// paddles, the ball and a dashed centre line, from a once-per-frame coordinate snapshot.
module pong_vga_renderer #(
  parameter int CLK_DIV   = 2,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int BALL_SIZE = 8,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [9:0] p1x_export,
  input  logic [9:0] p1y_export,
  input  logic [9:0] p2x_export,
  input  logic [9:0] p2y_export,
  input  logic [9:0] bx_export,
  input  logic [9:0] by_export,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] LINE_L   = 10'(H_ACTIVE / 2 - 2);
  localparam logic [9:0] LINE_R   = 10'(H_ACTIVE / 2 + 1);

  logic [DIV_W-1:0] div_reg;
  logic [9:0]       hcnt_reg, vcnt_reg;
  logic             pix_en, snap;
  logic [9:0]       coord_in [6];
  logic [9:0]       shadow_reg [6];
  logic [2:0]       obj_hit;
  logic             visible, line_hit;
  logic [11:0]      rgb_reg, rgb_next;
  logic             hs_reg, vs_reg, de_reg, tick_reg;

  assign pix_en = (div_reg == DIV_LAST);
  assign snap   = pix_en && (hcnt_reg == '0) && (vcnt_reg == V_VIS);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_reg  <= '0;
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (pix_en) begin
      div_reg <= '0;
      if (hcnt_reg == H_LAST) begin
        hcnt_reg <= '0;
        vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 10'd1;
      end else begin
        hcnt_reg <= hcnt_reg + 10'd1;
      end
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Object order: 0 = ball, 1 = paddle 1, 2 = paddle 2; x at even index, y at odd.
  assign coord_in[0] = bx_export;
  assign coord_in[1] = by_export;
  assign coord_in[2] = p1x_export;
  assign coord_in[3] = p1y_export;
  assign coord_in[4] = p2x_export;
  assign coord_in[5] = p2y_export;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 6; i++) shadow_reg[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < 6; i++) shadow_reg[i] <= coord_in[i];
    end
  end

  // Widening to 11 bits keeps x+W from wrapping for objects parked near 1023.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      localparam int OBJ_W = (gi == 0) ? BALL_SIZE : PADDLE_W;
      localparam int OBJ_H = (gi == 0) ? BALL_SIZE : PADDLE_H;
      logic [10:0] x0, y0, h11, v11;
      assign x0  = {1'b0, shadow_reg[2*gi]};
      assign y0  = {1'b0, shadow_reg[2*gi+1]};
      assign h11 = {1'b0, hcnt_reg};
      assign v11 = {1'b0, vcnt_reg};
      assign obj_hit[gi] = (h11 >= x0) && (h11 < x0 + 11'(OBJ_W)) &&
                           (v11 >= y0) && (v11 < y0 + 11'(OBJ_H));
    end
  endgenerate

  assign visible  = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
  assign line_hit = (hcnt_reg >= LINE_L) && (hcnt_reg <= LINE_R) && !vcnt_reg[3];

  always_comb begin
    rgb_next = 12'h000;
    if (visible) begin
      if (obj_hit[0])      rgb_next = 12'hFFF;
      else if (obj_hit[1]) rgb_next = 12'h0F0;
      else if (obj_hit[2]) rgb_next = 12'hF00;
      else if (line_hit)   rgb_next = 12'h888;
      else                 rgb_next = 12'h001;
    end
  end

  // Outputs describe the counter position of the previous pixel enable, all in lockstep.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hs_reg   <= 1'b1;
      vs_reg   <= 1'b1;
      de_reg   <= 1'b0;
      rgb_reg  <= 12'h000;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= snap;
      if (pix_en) begin
        hs_reg  <= !((hcnt_reg >= HS_BEG) && (hcnt_reg <= HS_END));
        vs_reg  <= !((vcnt_reg >= VS_BEG) && (vcnt_reg <= VS_END));
        de_reg  <= visible;
        rgb_reg <= rgb_next;
      end
    end
  end

  assign vga_hs     = hs_reg;
  assign vga_vs     = vs_reg;
  assign vga_de     = de_reg;
  assign vga_r      = rgb_reg[11:8];
  assign vga_g      = rgb_reg[7:4];
  assign vga_b      = rgb_reg[3:0];
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Scoreboard bench for pong_vga_renderer on a reduced 80x54 raster (64x48 visible)
// so that several frames, a mid-frame reset and clipping cases fit in a short run.
module tb_pong_vga_renderer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic [9:0] p1x, p1y, p2x, p2y, bx, by;
  logic       vga_hs, vga_vs, vga_de, frame_tick;
  logic [3:0] vga_r, vga_g, vga_b;

  pong_vga_renderer #(
    .CLK_DIV(2), .PADDLE_W(4), .PADDLE_H(16), .BALL_SIZE(4),
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk_clk(clk), .reset_reset(srst),
    .p1x_export(p1x), .p1y_export(p1y), .p2x_export(p2x), .p2y_export(p2y),
    .bx_export(bx), .by_export(by),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
  );

  typedef struct {
    int unsigned t;
    string       name;
    logic [15:0] want;  // {hs, vs, de, tick, r, g, b}
  } exp_t;

  exp_t        q[$];
  int unsigned clk_n = 0;
  int unsigned base_t = 4;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) clk_n <= clk_n + 1;

  task automatic push(input int unsigned t, input string name, input logic hs, input logic vs,
                      input logic de, input logic tick, input logic [11:0] rgb);
    exp_t e;
    e.t = t; e.name = name; e.want = {hs, vs, de, tick, rgb};
    q.push_back(e);
  endtask

  // Pixel (x,y) of frame f counted from the last reset release appears after edge 2*(L+1).
  function automatic int unsigned pix_t(input int f, input int x, input int y);
    return base_t + 2 * (f * 4320 + y * 80 + x) + 2;
  endfunction

  task automatic exp_pix(input string name, input int f, input int x, input int y,
                         input logic [11:0] rgb);
    logic de, hs, vs;
    de = (x < 64) && (y < 48);
    hs = !((x >= 68) && (x <= 75));
    vs = !((y >= 50) && (y <= 51));
    push(pix_t(f, x, y), name, hs, vs, de, 1'b0, de ? rgb : 12'h000);
  endtask

  task automatic exp_tick(input int k);
    int unsigned t;
    t = base_t + 2 * (k * 4320 + 3840) + 2;
    push(t - 1, "tick_before", 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    push(t,     "tick",        1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
    push(t + 1, "tick_after",  1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic wait_until(input int unsigned n);
    while (clk_n < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Monitor: scoreboard pops plus per-frame sync/enable accounting between ticks.
  int  w_clk, w_hs, w_vs, w_de;
  bit  have_prev = 1'b0;
  always @(negedge clk) begin
    logic [15:0] got;
    got = {vga_hs, vga_vs, vga_de, frame_tick, vga_r, vga_g, vga_b};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t <= clk_n) begin
        checks++;
        if (q[i].t < clk_n) begin
          errors++;
          $display("FAIL %s: sample at t=%0d missed (now %0d)", q[i].name, q[i].t, clk_n);
        end else if (got !== q[i].want) begin
          errors++;
          $display("FAIL %s t=%0d: got hs/vs/de/tick=%b rgb=%h, expected hs/vs/de/tick=%b rgb=%h",
                   q[i].name, clk_n, got[15:12], got[11:0], q[i].want[15:12], q[i].want[11:0]);
        end else begin
          $display("ok   %s t=%0d hs/vs/de/tick=%b rgb=%h", q[i].name, clk_n, got[15:12], got[11:0]);
        end
        q.delete(i);
      end
    end
    if (srst) begin
      have_prev = 1'b0;
    end else begin
      if (frame_tick) begin
        if (have_prev) begin
          chk("frame_period_clks", w_clk, 8640);
          chk("hsync_low_clks",    w_hs,  864);
          chk("vsync_low_clks",    w_vs,  320);
          chk("de_high_clks",      w_de,  6144);
        end
        have_prev = 1'b1;
        w_clk = 0; w_hs = 0; w_vs = 0; w_de = 0;
      end
      w_clk++;
      if (!vga_hs) w_hs++;
      if (!vga_vs) w_vs++;
      if (vga_de)  w_de++;
    end
  end

  initial begin
    srst = 1'b1;
    p1x = 10'd2;  p1y = 10'd10;
    p2x = 10'd58; p2y = 10'd10;
    bx  = 10'd30; by  = 10'd18;

    push(2, "reset_hold",    1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    push(5, "before_pix_en", 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    // Frame 0 renders the zeroed shadows: all objects stacked at the origin.
    exp_pix("f0_ball_origin", 0, 0, 0, 12'hFFF);
    exp_pix("f0_p1_origin",   0, 2, 10, 12'h0F0);
    exp_pix("f0_bg",          0, 10, 10, 12'h001);
    exp_pix("f0_line",        0, 31, 0, 12'h888);
    exp_pix("f0_line_gap",    0, 31, 8, 12'h001);
    exp_pix("f0_right_edge",  0, 63, 0, 12'h001);
    exp_pix("f0_front_porch", 0, 64, 0, 12'h000);
    exp_pix("f0_hsync",       0, 70, 10, 12'h000);
    exp_pix("f0_last_row",    0, 10, 47, 12'h001);
    exp_pix("f0_vsync",       0, 0, 50, 12'h000);
    for (int k = 0; k < 4; k++) exp_tick(k);
    exp_pix("f1_p1_tl",      1, 2, 10, 12'h0F0);
    exp_pix("f1_p1",         1, 3, 12, 12'h0F0);
    exp_pix("f1_p1_br",      1, 5, 25, 12'h0F0);
    exp_pix("f1_p1_right",   1, 6, 25, 12'h001);
    exp_pix("f1_p1_below",   1, 3, 26, 12'h001);
    exp_pix("f1_p2_left",    1, 57, 12, 12'h001);
    exp_pix("f1_p2",         1, 60, 25, 12'h F00);
    exp_pix("f1_p2_below",   1, 60, 26, 12'h001);
    exp_pix("f1_line",       1, 31, 0, 12'h888);
    exp_pix("f1_line_gap",   1, 31, 8, 12'h001);
    exp_pix("f1_line16",     1, 31, 16, 12'h888);
    exp_pix("f1_ball",       1, 31, 20, 12'hFFF);
    exp_pix("f1_ball_right", 1, 34, 20, 12'h001);

    wait_until(4);
    #2 srst = 1'b0;

    // Move the ball mid-frame: frame 1 keeps the old position, frame 2 shows the new one.
    wait_until(pix_t(1, 0, 10));
    bx = 10'd10;
    exp_pix("f1_old_snapshot", 1, 11, 20, 12'h001);
    exp_pix("f2_ball_tl",      2, 10, 18, 12'hFFF);
    exp_pix("f2_ball",         2, 11, 20, 12'hFFF);
    exp_pix("f2_ball_right",   2, 14, 18, 12'h001);
    exp_pix("f2_line",         2, 31, 20, 12'h888);

    // Park the ball near 1023 and push paddle 1 past the right edge.
    wait_until(pix_t(2, 0, 30));
    bx = 10'd1020; by = 10'd1020; p1x = 10'd62;
    exp_pix("f3_origin",      3, 0, 0, 12'h001);
    exp_pix("f3_no_wrap",     3, 1, 1, 12'h001);
    exp_pix("f3_p2",          3, 61, 12, 12'hF00);
    exp_pix("f3_p1_clip_l",   3, 62, 12, 12'h0F0);
    exp_pix("f3_p1_clip_r",   3, 63, 12, 12'h0F0);
    exp_pix("f3_clip_invis",  3, 64, 12, 12'h000);
    exp_pix("f3_line",        3, 31, 20, 12'h888);
    push(pix_t(4, 39, 30) + 1, "f4_pre_reset", 1'b1, 1'b1, 1'b1, 1'b0, 12'h001);

    // One-clock reset while the counters sit at (40,30) of frame 4.
    wait_until(pix_t(4, 39, 30) + 1);
    #2 srst = 1'b1;
    push(clk_n + 1, "mid_reset", 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    base_t = clk_n + 1;
    exp_pix("rst_f0_ball_origin", 0, 0, 0, 12'hFFF);
    exp_pix("rst_f0_p1_origin",   0, 2, 10, 12'h0F0);
    exp_tick(0);
    exp_pix("rst_f1_origin",      1, 0, 0, 12'h001);
    exp_pix("rst_f1_p1",          1, 62, 12, 12'h0F0);
    @(negedge clk);
    #2 srst = 1'b0;

    wait_until(pix_t(1, 62, 12) + 4);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
